// File: rtl/sbox_sub_bytes.sv
// Sequential AES SubBytes: walks a latched block through a shared byte-wide
// synchronous S-box ROM, one lookup per cycle, and reassembles the result.
//
// state  | meaning
// IDLE   | ready for a new block
// LOOKUP | issuing one ROM address per cycle
// DRAIN  | capturing the last ROM read
// DONE   | result valid, waiting for downstream
module sbox_sub_bytes #(
    parameter int NUM_BYTES   = 16,
    parameter int BYTE_WIDTH  = 8,
    parameter int ROM_LATENCY = 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             s_valid_i,
    output logic                             s_ready_o,
    input  logic [NUM_BYTES*BYTE_WIDTH-1:0]  s_data_i,
    output logic [BYTE_WIDTH-1:0]            rom_addr_o,
    input  logic [BYTE_WIDTH-1:0]            rom_data_i,
    output logic                             m_valid_o,
    input  logic                             m_ready_i,
    output logic [NUM_BYTES*BYTE_WIDTH-1:0]  m_data_o
);

    localparam int DW    = NUM_BYTES * BYTE_WIDTH;
    localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int DLY_W = ROM_LATENCY * IDX_W;
    localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(NUM_BYTES - 1);
    localparam logic [ROM_LATENCY-1:0] CAP_LAST = ROM_LATENCY'(1) << (ROM_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [DW-1:0]          in_q, in_d;
    logic [DW-1:0]          res_q, res_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [ROM_LATENCY-1:0] cap_q, cap_d;
    logic [DLY_W-1:0]       idx_dly_q, idx_dly_d;
    logic [IDX_W-1:0]       cap_idx;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            in_q      <= '0;
            res_q     <= '0;
            idx_q     <= '0;
            cap_q     <= '0;
            idx_dly_q <= '0;
        end else begin
            state_q   <= state_d;
            in_q      <= in_d;
            res_q     <= res_d;
            idx_q     <= idx_d;
            cap_q     <= cap_d;
            idx_dly_q <= idx_dly_d;
        end
    end

    // Capture pipeline tracks which issued index the ROM is returning now.
    assign cap_idx = idx_dly_q[DLY_W-1 -: IDX_W];

    always_comb begin
        state_d    = state_q;
        in_d       = in_q;
        res_d      = res_q;
        idx_d      = idx_q;
        cap_d      = ROM_LATENCY'({cap_q, (state_q == ST_LOOKUP)});
        idx_dly_d  = DLY_W'({idx_dly_q, idx_q});
        s_ready_o  = 1'b0;
        m_valid_o  = 1'b0;
        rom_addr_o = '0;

        if (cap_q[ROM_LATENCY-1]) begin
            res_d[cap_idx*BYTE_WIDTH +: BYTE_WIDTH] = rom_data_i;
        end

        case (state_q)
            ST_IDLE: begin
                s_ready_o = 1'b1;
                if (s_valid_i) begin
                    in_d    = s_data_i;
                    idx_d   = '0;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                rom_addr_o = in_q[idx_q*BYTE_WIDTH +: BYTE_WIDTH];
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DRAIN;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DRAIN: begin
                // Leave once the final outstanding read is being captured.
                if (cap_q == CAP_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                m_valid_o = 1'b1;
                if (m_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign m_data_o = res_q;

endmodule

// File: tb/tb_sbox_sub_bytes.sv
// Testbench for sbox_sub_bytes: models the S-box ROM, scoreboards every
// accepted block and checks ROM addresses, latency, backpressure and reset.
module tb_sbox_sub_bytes;

    localparam logic [2047:0] SBOX_FLAT = 2048'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0b7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b27509832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cfd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2cd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdbe0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08ba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9ee1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16;

    logic         clk;
    logic         rst;
    logic         s_valid;
    logic         s_ready;
    logic [127:0] s_data;
    logic [7:0]   rom_addr;
    logic [7:0]   rom_data;
    logic         m_valid;
    logic         m_ready;
    logic [127:0] m_data;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_acc = 0;

    logic [127:0] exp_q[$];
    int           acc_q[$];
    int           acc_hist[$];
    logic         addr_active = 1'b0;
    logic [127:0] addr_blk;
    int           addr_pos;
    logic         prev_mv = 1'b0;
    logic         prev_hs = 1'b0;
    logic [127:0] prev_md;

    typedef struct {
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;
    vec_t vecs[5];

    sbox_sub_bytes #(.NUM_BYTES(16), .BYTE_WIDTH(8), .ROM_LATENCY(1)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .s_valid_i (s_valid),
        .s_ready_o (s_ready),
        .s_data_i  (s_data),
        .rom_addr_o(rom_addr),
        .rom_data_i(rom_data),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready),
        .m_data_o  (m_data)
    );

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [2047:0] t;
        t = SBOX_FLAT;
        return t[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [127:0] sub_block(input logic [127:0] d);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = sbox(d[8*k +: 8]);
        return r;
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM model: one-cycle registered read.
    always @(posedge clk) rom_data <= sbox(rom_addr);

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
            addr_active = 1'b0;
            prev_mv = 1'b0;
            prev_hs = 1'b0;
        end else begin
            if (addr_active) begin
                check("rom_addr", rom_addr, addr_blk[8*addr_pos +: 8]);
                addr_pos++;
                if (addr_pos == 16) addr_active = 1'b0;
            end else begin
                check("rom_addr_idle", rom_addr, 0);
            end
            if (prev_mv && !prev_hs) begin
                check("m_valid_hold", m_valid, 1);
                check("m_data_hold", m_data, prev_md);
            end
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    check("m_valid_unexpected", m_valid, 0);
                end else begin
                    if (!prev_mv) check("latency", 128'(cyc - acc_q[0]), 18);
                    if (m_ready) begin
                        check("m_data", m_data, exp_q[0]);
                        void'(exp_q.pop_front());
                        void'(acc_q.pop_front());
                    end
                end
            end
            prev_mv = m_valid;
            prev_md = m_data;
            prev_hs = m_valid && m_ready;
            if (s_valid && s_ready) begin
                exp_q.push_back(sub_block(s_data));
                acc_q.push_back(cyc);
                acc_hist.push_back(cyc);
                n_acc++;
                addr_active = 1'b1;
                addr_blk = s_data;
                addr_pos = 0;
            end
        end
    end

    task automatic send(input logic [127:0] d);
        bit got;
        got = 1'b0;
        s_valid = 1'b1;
        s_data = d;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (s_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("send_timeout", s_ready, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_out();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (m_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("out_timeout", m_valid, 1);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] a;
        logic [127:0] blk[4];
        int           base;
        int           acc0;
        bit           done;

        vecs[0].din = '0;
        vecs[0].dout = {16{8'h63}};
        vecs[1].din = 128'h082a2bbe488de2e3f8c6f43de99aa019;
        vecs[1].dout = 128'h30e5f1ae525d981141b4bf271eb8e0d4;
        vecs[2].din = 128'h0f0e0d0c0b0a09080706050403020100;
        vecs[2].dout = 128'h76abd7fe2b670130c56f6bf27b777c63;
        vecs[3].din = {16{8'hff}};
        vecs[3].dout = {16{8'h16}};
        vecs[4].din = {16{8'h01}};
        vecs[4].dout = {16{8'h7c}};

        rst = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        m_ready = 1'b1;
        #1 rst = 1'b1;
        #2;
        check("rst_s_ready", s_ready, 1);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_rom_addr", rom_addr, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Table-driven known-answer blocks.
        for (int v = 0; v < 5; v++) begin
            send(vecs[v].din);
            wait_out();
            check("vec_data", m_data, vecs[v].dout);
            @(posedge clk);
            #1;
        end

        // Backpressure: output held for 10 cycles.
        m_ready = 1'b0;
        a = rnd128();
        send(a);
        wait_out();
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            check("bp_m_valid", m_valid, 1);
            check("bp_m_data", m_data, sub_block(a));
            check("bp_s_ready", s_ready, 0);
        end
        @(posedge clk);
        #1 m_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_s_ready", s_ready, 1);
        check("bp_release_m_valid", m_valid, 0);
        @(posedge clk);
        #1;

        // Busy: input traffic during LOOKUP is ignored.
        acc0 = n_acc;
        a = rnd128();
        send(a);
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1;
            s_data = rnd128();
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        wait_out();
        check("busy_data", m_data, sub_block(a));
        check("busy_accepts", 128'(n_acc - acc0), 1);
        @(posedge clk);
        #1;

        // Reset in LOOKUP cycle 7 discards the block.
        send(rnd128());
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_m_valid", m_valid, 0);
        check("midrst_m_data", m_data, 0);
        check("midrst_s_ready", s_ready, 1);
        check("midrst_rom_addr", rom_addr, 0);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        check("postrst_s_ready", s_ready, 1);
        send({16{8'h01}});
        wait_out();
        check("postrst_data", m_data, {16{8'h7c}});
        @(posedge clk);
        #1;

        // Back-to-back with valid and ready held high.
        for (int i = 0; i < 4; i++) blk[i] = rnd128();
        base = acc_hist.size();
        m_ready = 1'b1;
        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_data = blk[i];
            done = 1'b0;
            for (int j = 0; j < 60; j++) begin
                @(negedge clk);
                if (s_ready) begin
                    done = 1'b1;
                    break;
                end
            end
            if (!done) check("b2b_accept_timeout", s_ready, 1);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        for (int j = 0; j < 60 && exp_q.size() != 0; j++) @(negedge clk);
        check("b2b_accept_count", 128'(acc_hist.size() - base), 4);
        if (acc_hist.size() - base == 4) begin
            for (int i = 1; i < 4; i++)
                check("b2b_spacing", 128'(acc_hist[base+i] - acc_hist[base+i-1]), 19);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 128'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
